csr_timer_bank: RTL
===================

# csr_timer_bank

Parametrised timer/counter CSR bank for the LoongArch core: NUM_TIMERS independent countdown timers (one-shot or periodic), a shared timer ID, and a free-running stable counter with optional software compensation. Sits beside the main CSR file on the same read/write CSR port. Its per-timer pending vector feeds the ESTAT interrupt-status bits that drive has_int.

## Interface
- NUM_TIMERS, 1: number of timer channels, range 1–8.
- TIMER_W, 32: TVAL/INITVAL counter width, range 8–32. Unused upper CSR bits read 0.
- STABLE_W, 64: stable counter width, range 8–64.
- TID_RESET, 32'h0: reset value of TID.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- csr_raddr  in  14  read address.
- csr_rdata  out  32  read data; combinational; 0 for unmapped addresses.
- csr_hit  out  1  csr_raddr maps to a register in this bank.
- csr_we  in  1  write strobe.
- csr_waddr  in  14  write address.
- csr_wdata  in  32  write data.
- timer_irq  out  NUM_TIMERS  per-channel pending bit, registered.
- time_cnt  out  STABLE_W  stable counter value, compensated when CSR_CNTC_EN is defined.
- time_tid  out  32  current TID.

## Operation
- Address map:
  - TID is at 0x40; CNTC is at 0x43.
  - Channel i uses base 0x41 + 8*i: TCFG at +0, TVAL at +1, TICLR at +3.
  - Channel 0 therefore sits at 0x41/0x42/0x44.
- TCFG layout: bit0 EN, bit1 PERIODIC, [TIMER_W-1:2] INITVAL. Reads return the stored value.
- Writing TCFG:
  - TVAL <= {INITVAL, 2'b00} and en <= wdata[0].
  - If EN=0 is written, TVAL is loaded but frozen.
- While en=1 and TVAL != 0: TVAL decrements by 1 per cycle.
- Expiry (en=1 and TVAL == 0):
  - pending[i] <= 1.
  - If PERIODIC=1: TVAL <= {INITVAL, 00} and en stays 1.
  - If PERIODIC=0: TVAL <= all ones (TIMER_W bits) and en <= 0.
- TICLR:
  - Writing with wdata[0]=1 clears pending[i]; other bits are ignored.
  - TICLR always reads 0.
- TVAL is read-only; writes to it are ignored.
- Stable counter: increments every cycle and wraps from all-ones to 0.
- TID: read/write, 32 bits.

## Timing
- Reset values:
  - tcfg = 0, en = 0, TVAL = all ones, pending = 0.
  - Stable counter = 0, TID = TID_RESET, CNTC = 0.
  - timer_irq = 0, time_cnt = 0.
- All writes take effect at the clock edge where csr_we=1. A read in the following cycle returns the new value. csr_rdata has zero latency.
- Expiry latency: TCFG written at edge 0 with INITVAL=N. TVAL reaches 0 after edge 4N. pending rises at edge 4N+1.
- Same-cycle collisions:
  - Expiry with TICLR clear: set wins, so pending=1 and no event is lost.
  - Expiry with a TCFG write to the same channel: the TCFG write wins and that expiry is discarded.
- reset asserted mid-countdown returns everything to reset values on that edge.

## Configuration
- CSR_CNTC_EN defined:
  - CNTC at 0x43 is a 32-bit read/write register.
  - time_cnt = raw counter + sign-extended CNTC, modulo 2^STABLE_W.
- CSR_CNTC_EN undefined:
  - 0x43 is unmapped: csr_hit=0, reads 0, writes are ignored.
  - time_cnt = raw counter.

## Structure
- Package csr_timer_pkg holds:
  - Address constants: TID, CNTC, timer base, channel stride 8, TCFG/TVAL/TICLR offsets.
  - TCFG bit positions: EN, PERIODIC, INITVAL lsb.
  - The TICLR CLR bit.
- Sub-module csr_timer_chan:
  - One instance per channel via generate.
  - Holds tcfg, TVAL, en and pending.
  - Inputs: decoded tcfg_we, ticlr_we, wdata.
  - Outputs: tcfg, tval, pending.
- The top level holds address decode, the read mux, TID, CNTC and the stable counter.

## Test plan
- One-shot: write TCFG=0x9 (EN=1, PERIODIC=0, INITVAL=2) to ch0 -> TVAL=8, counts to 0, timer_irq[0] rises 9 edges after the write, then TVAL=0xFFFFFFFF and counting stops.
- Periodic: TCFG=0xB -> timer_irq[0] rises at 9 edges; TICLR=1 clears it; it rises again 9 edges after the previous expiry.
- Collision: issue TICLR clear on the exact expiry edge -> pending stays 1. Issue a TCFG rewrite on the expiry edge -> pending stays 0 and TVAL is reloaded.
- Multichannel: NUM_TIMERS=4 with INITVAL 1,2,3,4 started on the same cycle -> irq bits rise at 5, 9, 13 and 17 edges. Clearing ch2 leaves the others set. Reads of each TVAL are correct.
- Counter wrap, STABLE_W=8: after reset, time_cnt reaches 255 then 0 after 256 edges.
- CNTC with CSR_CNTC_EN: write CNTC=0xFFFFFFFF -> time_cnt = raw-1. Without the macro, 0x43 reads 0 and csr_hit=0.
- Reset mid-operation: assert reset while ch0 is at TVAL=5 -> TVAL=all ones, en=0, irq=0, and TID=TID_RESET on the next cycle.

Source files
------------

// File: rtl/csr_timer_pkg.sv
// Shared constants, decode types and the CSR address decoder for csr_timer_bank.
package csr_timer_pkg;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned CSR_W  = 32;

  // Register addresses
  localparam logic [ADDR_W-1:0] ADDR_TID        = 14'h040;
  localparam logic [ADDR_W-1:0] ADDR_CNTC       = 14'h043;
  localparam logic [ADDR_W-1:0] ADDR_TIMER_BASE = 14'h041;
  localparam int unsigned       CHAN_STRIDE     = 8;

  // Per-channel register offsets from the channel base
  localparam logic [2:0] OFS_TCFG  = 3'd0;
  localparam logic [2:0] OFS_TVAL  = 3'd1;
  localparam logic [2:0] OFS_TICLR = 3'd3;

  // TCFG / TICLR field positions
  localparam int unsigned TCFG_EN_BIT       = 0;
  localparam int unsigned TCFG_PERIODIC_BIT = 1;
  localparam int unsigned TCFG_INITVAL_LSB  = 2;
  localparam int unsigned TICLR_CLR_BIT     = 0;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_TID,
    REG_CNTC,
    REG_TCFG,
    REG_TVAL,
    REG_TICLR
  } csr_reg_e;

  typedef struct packed {
    csr_reg_e   kind;
    logic [2:0] chan;
  } csr_dec_t;

  // Map a CSR address onto a register kind and channel index.
  function automatic csr_dec_t csr_decode(input logic [ADDR_W-1:0] addr,
                                          input int unsigned       num_timers,
                                          input logic              cntc_en);
    csr_dec_t          dec;
    logic [ADDR_W-1:0] rel;
    logic [2:0]        ofs;
    dec.kind = REG_NONE;
    dec.chan = '0;
    rel      = addr - ADDR_TIMER_BASE;
    ofs      = rel[2:0];
    if (addr == ADDR_TID) begin
      dec.kind = REG_TID;
    end else if (addr == ADDR_CNTC) begin
      if (cntc_en) dec.kind = REG_CNTC;
    end else if ((addr >= ADDR_TIMER_BASE) &&
                 (rel < ADDR_W'(num_timers * CHAN_STRIDE))) begin
      dec.chan = 3'(rel >> 3);
      case (ofs)
        OFS_TCFG:  dec.kind = REG_TCFG;
        OFS_TVAL:  dec.kind = REG_TVAL;
        OFS_TICLR: dec.kind = REG_TICLR;
        default:   dec.kind = REG_NONE;
      endcase
    end
    return dec;
  endfunction

endpackage

// File: rtl/csr_timer_chan.sv
// One countdown timer channel: TCFG storage, TVAL down-counter, enable and pending flag.
module csr_timer_chan
  import csr_timer_pkg::*;
#(
  parameter int unsigned TIMER_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tcfg_we,
  input  logic               ticlr_we,
  input  logic [TIMER_W-1:0] wdata,
  output logic [TIMER_W-1:0] tcfg,
  output logic [TIMER_W-1:0] tval,
  output logic               pending
);

  logic               en;
  logic               expire;
  logic               clr;
  logic [TIMER_W-1:0] reload_wr;
  logic [TIMER_W-1:0] reload_cur;

  assign expire     = en && (tval == '0);
  assign clr        = ticlr_we && wdata[TICLR_CLR_BIT];
  assign reload_wr  = {wdata[TIMER_W-1:TCFG_INITVAL_LSB], 2'b00};
  assign reload_cur = {tcfg[TIMER_W-1:TCFG_INITVAL_LSB], 2'b00};

  // Config and counter: a TCFG write overrides any expiry on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcfg <= '0;
      tval <= '1;
      en   <= 1'b0;
    end else if (tcfg_we) begin
      tcfg <= wdata;
      tval <= reload_wr;
      en   <= wdata[TCFG_EN_BIT];
    end else if (expire) begin
      if (tcfg[TCFG_PERIODIC_BIT]) begin
        tval <= reload_cur;
      end else begin
        tval <= '1;
        en   <= 1'b0;
      end
    end else if (en) begin
      tval <= tval - TIMER_W'(1);
    end
  end

  // Pending flag: a live expiry beats a same-edge clear so no event is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (expire && !tcfg_we) begin
      pending <= 1'b1;
    end else if (clr) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/csr_timer_bank.sv
// Timer/counter CSR bank: NUM_TIMERS countdown channels, TID and a stable counter.
// Optional feature macro: CSR_CNTC_EN adds the CNTC compensation register at 0x43.
module csr_timer_bank
  import csr_timer_pkg::*;
#(
  parameter int unsigned NUM_TIMERS = 1,
  parameter int unsigned TIMER_W    = 32,
  parameter int unsigned STABLE_W   = 64,
  parameter logic [31:0] TID_RESET  = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     csr_raddr,
  output logic [CSR_W-1:0]      csr_rdata,
  output logic                  csr_hit,
  input  logic                  csr_we,
  input  logic [ADDR_W-1:0]     csr_waddr,
  input  logic [CSR_W-1:0]      csr_wdata,
  output logic [NUM_TIMERS-1:0] timer_irq,
  output logic [STABLE_W-1:0]   time_cnt,
  output logic [31:0]           time_tid
);

`ifdef CSR_CNTC_EN
  localparam logic CNTC_EN = 1'b1;
`else
  localparam logic CNTC_EN = 1'b0;
`endif

  csr_dec_t              rdec;
  csr_dec_t              wdec;
  logic [NUM_TIMERS-1:0] tcfg_we;
  logic [NUM_TIMERS-1:0] ticlr_we;
  logic [NUM_TIMERS-1:0] pending;
  logic [TIMER_W-1:0]    tcfg_q [NUM_TIMERS];
  logic [TIMER_W-1:0]    tval_q [NUM_TIMERS];
  logic [31:0]           tid;
  logic [STABLE_W-1:0]   stable_cnt;
  logic                  tid_we;

  assign rdec   = csr_decode(csr_raddr, NUM_TIMERS, CNTC_EN);
  assign wdec   = csr_decode(csr_waddr, NUM_TIMERS, CNTC_EN);
  assign csr_hit = (rdec.kind != REG_NONE);
  assign tid_we = csr_we && (wdec.kind == REG_TID);

  // Per-channel write strobes from the decoded write address.
  always_comb begin
    tcfg_we  = '0;
    ticlr_we = '0;
    for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
      tcfg_we[i]  = csr_we && (wdec.kind == REG_TCFG)  && (wdec.chan == 3'(i));
      ticlr_we[i] = csr_we && (wdec.kind == REG_TICLR) && (wdec.chan == 3'(i));
    end
  end

  for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_chan
    csr_timer_chan #(
      .TIMER_W (TIMER_W)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .tcfg_we  (tcfg_we[g]),
      .ticlr_we (ticlr_we[g]),
      .wdata    (csr_wdata[TIMER_W-1:0]),
      .tcfg     (tcfg_q[g]),
      .tval     (tval_q[g]),
      .pending  (pending[g])
    );
  end

  assign timer_irq = pending;
  assign time_tid  = tid;

  // TID register.
  always_ff @(posedge clk) begin
    if (reset) begin
      tid <= TID_RESET;
    end else if (tid_we) begin
      tid <= csr_wdata;
    end
  end

  // Free-running stable counter, wraps naturally at STABLE_W bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + STABLE_W'(1);
    end
  end

`ifdef CSR_CNTC_EN
  logic [31:0] cntc;

  // Software compensation offset, applied sign-extended to the counter view.
  always_ff @(posedge clk) begin
    if (reset) begin
      cntc <= '0;
    end else if (csr_we && (wdec.kind == REG_CNTC)) begin
      cntc <= csr_wdata;
    end
  end

  assign time_cnt = stable_cnt + STABLE_W'({{32{cntc[31]}}, cntc});
`else
  assign time_cnt = stable_cnt;
`endif

  // Zero-latency read mux; unmapped addresses and TICLR read as 0.
  always_comb begin
    csr_rdata = '0;
    case (rdec.kind)
      REG_TID: csr_rdata = tid;
`ifdef CSR_CNTC_EN
      REG_CNTC: csr_rdata = cntc;
`endif
      REG_TCFG: begin
        for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
          if (rdec.chan == 3'(i)) csr_rdata = 32'(tcfg_q[i]);
        end
      end
      REG_TVAL: begin
        for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
          if (rdec.chan == 3'(i)) csr_rdata = 32'(tval_q[i]);
        end
      end
      default: csr_rdata = '0;
    endcase
  end

endmodule
